// File: rtl/amm_pkt_driver.sv
// rtl/amm_pkt_driver.sv - Avalon-MM burst driver for word-level test packets.
// Optional macro AMM_PKT_DRIVER_STAT_EN enables the write-beat / read-command counters.
module amm_pkt_driver #(
    parameter int AMM_DATA_W    = 128,
    parameter int AMM_ADDR_W    = 12,
    parameter int AMM_BURST_W   = 11,
    parameter int BYTE_PER_WORD = AMM_DATA_W / 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     pkt_valid_i,
    output logic                     pkt_ready_o,
    input  logic                     pkt_write_i,
    input  logic [AMM_ADDR_W-1:0]    pkt_word_addr_i,
    input  logic [AMM_BURST_W-1:0]   pkt_burst_cnt_i,
    input  logic [BYTE_PER_WORD-1:0] pkt_start_mask_i,
    input  logic [BYTE_PER_WORD-1:0] pkt_end_mask_i,
    input  logic [7:0]               pkt_data_ptrn_i,
    input  logic                     pkt_data_ptrn_type_i,
    output logic [AMM_ADDR_W-1:0]    amm_address_o,
    output logic [AMM_BURST_W-1:0]   amm_burstcount_o,
    output logic                     amm_write_o,
    output logic                     amm_read_o,
    output logic [AMM_DATA_W-1:0]    amm_writedata_o,
    output logic [BYTE_PER_WORD-1:0] amm_byteenable_o,
    input  logic                     amm_waitrequest_i,
    output logic                     busy_o,
    output logic [31:0]              wr_beat_cnt_o,
    output logic [31:0]              rd_cmd_cnt_o
);

    localparam int LANES = AMM_DATA_W / 32;
    localparam logic [AMM_BURST_W-1:0] BURST_ONE = AMM_BURST_W'(1);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t                   state_q, state_d;
    logic                     ready_q, ready_d;
    logic [AMM_ADDR_W-1:0]    addr_q, addr_d;
    logic [AMM_BURST_W-1:0]   burst_q, burst_d;
    logic [AMM_BURST_W-1:0]   beat_q, beat_d;
    logic [BYTE_PER_WORD-1:0] emask_q, emask_d;
    logic [BYTE_PER_WORD-1:0] be_q, be_d;
    logic [AMM_DATA_W-1:0]    wdata_q, wdata_d;
    logic                     rnd_q, rnd_d;
    logic                     write_q, write_d;
    logic                     read_q, read_d;
    logic                     wr_acc, rd_acc;

    // Galois step for x^32+x^22+x^2+x+1, right-shifting form.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    assign wr_acc = write_q & ~amm_waitrequest_i;
    assign rd_acc = read_q & ~amm_waitrequest_i;

    always_comb begin
        logic [31:0] seed;
        state_d = state_q;
        ready_d = ready_q;
        addr_d  = addr_q;
        burst_d = burst_q;
        beat_d  = beat_q;
        emask_d = emask_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rnd_d   = rnd_q;
        write_d = write_q;
        read_d  = read_q;
        seed    = 32'h0;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                // Zero-length packets are accepted and silently dropped.
                if (pkt_valid_i && ready_q && (pkt_burst_cnt_i != '0)) begin
                    ready_d = 1'b0;
                    addr_d  = pkt_word_addr_i;
                    burst_d = pkt_burst_cnt_i;
                    beat_d  = '0;
                    emask_d = pkt_end_mask_i;
                    rnd_d   = pkt_data_ptrn_type_i;
                    if (pkt_write_i) begin
                        state_d = WRITE;
                        write_d = 1'b1;
                        be_d    = (pkt_burst_cnt_i == BURST_ONE) ?
                                  (pkt_start_mask_i & pkt_end_mask_i) : pkt_start_mask_i;
                        if (pkt_data_ptrn_type_i) begin
                            for (int i = 0; i < LANES; i++) begin
                                seed = {4{pkt_data_ptrn_i}} ^ 32'(i);
                                wdata_d[i*32 +: 32] = (seed == 32'h0) ? 32'h1 : seed;
                            end
                        end else begin
                            wdata_d = {BYTE_PER_WORD{pkt_data_ptrn_i}};
                        end
                    end else begin
                        state_d = READ;
                        read_d  = 1'b1;
                        be_d    = '0;
                        wdata_d = '0;
                    end
                end
            end
            WRITE: begin
                if (wr_acc) begin
                    if (beat_q == burst_q - BURST_ONE) begin
                        state_d = IDLE;
                        write_d = 1'b0;
                        ready_d = 1'b1;
                    end else begin
                        beat_d = beat_q + BURST_ONE;
                        be_d   = (beat_q + BURST_ONE == burst_q - BURST_ONE) ? emask_q : '1;
                        // LFSR state lives in the writedata register itself.
                        if (rnd_q) begin
                            for (int i = 0; i < LANES; i++) begin
                                wdata_d[i*32 +: 32] = lfsr_step(wdata_q[i*32 +: 32]);
                            end
                        end
                    end
                end
            end
            READ: begin
                if (rd_acc) begin
                    state_d = IDLE;
                    read_d  = 1'b0;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                write_d = 1'b0;
                read_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            addr_q  <= '0;
            burst_q <= '0;
            beat_q  <= '0;
            emask_q <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rnd_q   <= 1'b0;
            write_q <= 1'b0;
            read_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            addr_q  <= addr_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
            emask_q <= emask_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rnd_q   <= rnd_d;
            write_q <= write_d;
            read_q  <= read_d;
        end
    end

`ifdef AMM_PKT_DRIVER_STAT_EN
    logic [31:0] wr_cnt_q, rd_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            if (wr_acc) wr_cnt_q <= wr_cnt_q + 32'd1;
            if (rd_acc) rd_cnt_q <= rd_cnt_q + 32'd1;
        end
    end

    assign wr_beat_cnt_o = wr_cnt_q;
    assign rd_cmd_cnt_o  = rd_cnt_q;
`else
    assign wr_beat_cnt_o = 32'h0;
    assign rd_cmd_cnt_o  = 32'h0;
`endif

    assign pkt_ready_o      = ready_q;
    assign busy_o           = (state_q != IDLE);
    assign amm_address_o    = addr_q;
    assign amm_burstcount_o = burst_q;
    assign amm_write_o      = write_q;
    assign amm_read_o       = read_q;
    assign amm_writedata_o  = wdata_q;
    assign amm_byteenable_o = be_q;

endmodule

// File: tb/tb_amm_pkt_driver.sv
// tb/tb_amm_pkt_driver.sv - self-checking bench for amm_pkt_driver with a packet-level model.
module tb_amm_pkt_driver;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         pkt_valid = 1'b0;
    logic         pkt_ready;
    logic         pkt_write = 1'b0;
    logic [11:0]  pkt_addr = '0;
    logic [10:0]  pkt_burst = '0;
    logic [15:0]  pkt_smask = '0;
    logic [15:0]  pkt_emask = '0;
    logic [7:0]   pkt_ptrn = '0;
    logic         pkt_type = 1'b0;
    logic [11:0]  amm_address;
    logic [10:0]  amm_burstcount;
    logic         amm_write;
    logic         amm_read;
    logic [127:0] amm_writedata;
    logic [15:0]  amm_byteenable;
    logic         waitreq = 1'b0;
    logic         busy;
    logic [31:0]  wr_cnt;
    logic [31:0]  rd_cnt;

    amm_pkt_driver dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .pkt_valid_i(pkt_valid), .pkt_ready_o(pkt_ready), .pkt_write_i(pkt_write),
        .pkt_word_addr_i(pkt_addr), .pkt_burst_cnt_i(pkt_burst),
        .pkt_start_mask_i(pkt_smask), .pkt_end_mask_i(pkt_emask),
        .pkt_data_ptrn_i(pkt_ptrn), .pkt_data_ptrn_type_i(pkt_type),
        .amm_address_o(amm_address), .amm_burstcount_o(amm_burstcount),
        .amm_write_o(amm_write), .amm_read_o(amm_read),
        .amm_writedata_o(amm_writedata), .amm_byteenable_o(amm_byteenable),
        .amm_waitrequest_i(waitreq), .busy_o(busy),
        .wr_beat_cnt_o(wr_cnt), .rd_cmd_cnt_o(rd_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         wr;
        logic [11:0]  addr;
        logic [10:0]  burst;
        logic [15:0]  be;
        logic [127:0] data;
    } beat_t;

    beat_t        exp_q[$];
    bit           wait_q[$];
    bit           rnd_wait = 1'b0;
    logic [127:0] acc_data[$];
    logic [15:0]  acc_be[$];
    int           n_cmp = 0;
    int           n_fail = 0;
    int           m_wr = 0;
    int           m_rd = 0;
    int           wr_hi = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] stat(input int v);
`ifdef AMM_PKT_DRIVER_STAT_EN
        return 32'(v);
`else
        return 32'(0 * v);
`endif
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // Expected beat list for one packet, built straight from the packet rules.
    task automatic model_pkt(input bit wr, input logic [11:0] addr, input logic [10:0] burst,
                             input logic [15:0] sm, input logic [15:0] em,
                             input logic [7:0] p, input bit t);
        beat_t       b;
        logic [31:0] lane[4];
        int          nb;
        nb = int'(burst);
        if (nb == 0) return;
        for (int i = 0; i < 4; i++) begin
            lane[i] = {4{p}} ^ 32'(i);
            if (lane[i] == 32'h0) lane[i] = 32'h1;
        end
        b.wr = wr; b.addr = addr; b.burst = burst;
        if (!wr) begin
            b.be = '0; b.data = '0;
            exp_q.push_back(b);
            return;
        end
        for (int k = 0; k < nb; k++) begin
            if (nb == 1)           b.be = sm & em;
            else if (k == 0)       b.be = sm;
            else if (k == nb - 1)  b.be = em;
            else                   b.be = 16'hFFFF;
            if (t) begin
                b.data = {lane[3], lane[2], lane[1], lane[0]};
                for (int i = 0; i < 4; i++) lane[i] = lfsr_next(lane[i]);
            end else begin
                b.data = {16{p}};
            end
            exp_q.push_back(b);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (busy && wait_q.size() > 0) waitreq = wait_q.pop_front();
        else if (busy && rnd_wait)     waitreq = 1'($urandom_range(0, 1));
        else                           waitreq = 1'b0;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            beat_t h;
            chk("wr_rd_excl", 128'(amm_write & amm_read), 128'(0));
            chk("wr_beat_cnt", 128'(wr_cnt), 128'(stat(m_wr)));
            chk("rd_cmd_cnt", 128'(rd_cnt), 128'(stat(m_rd)));
            if (amm_write) wr_hi++;
            if (amm_write || amm_read) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_cmd", 128'({amm_write, amm_read}), 128'(0));
                end else begin
                    h = exp_q[0];
                    chk("write", 128'(amm_write), 128'(h.wr));
                    chk("read", 128'(amm_read), 128'(!h.wr));
                    chk("address", 128'(amm_address), 128'(h.addr));
                    chk("burstcount", 128'(amm_burstcount), 128'(h.burst));
                    chk("byteenable", 128'(amm_byteenable), 128'(h.be));
                    chk("writedata", amm_writedata, h.data);
                    if (!waitreq) begin
                        void'(exp_q.pop_front());
                        if (h.wr) begin
                            m_wr++;
                            acc_data.push_back(amm_writedata);
                            acc_be.push_back(amm_byteenable);
                        end else begin
                            m_rd++;
                        end
                    end
                end
            end
        end
    end

    task automatic send(input bit wr, input logic [11:0] addr, input logic [10:0] burst,
                        input logic [15:0] sm, input logic [15:0] em,
                        input logic [7:0] p, input bit t);
        int n;
        model_pkt(wr, addr, burst, sm, em, p, t);
        pkt_write = wr; pkt_addr = addr; pkt_burst = burst;
        pkt_smask = sm; pkt_emask = em; pkt_ptrn = p; pkt_type = t;
        pkt_valid = 1'b1;
        n = 0;
        while (!pkt_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) chk("ready_timeout", 128'(pkt_ready), 128'(1));
        @(posedge clk); #1;
        pkt_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk); n++;
        end while ((busy || exp_q.size() != 0) && n < 300);
        if (n >= 300) begin
            chk("idle_timeout_busy", 128'(busy), 128'(0));
            chk("idle_timeout_pending", 128'(exp_q.size()), 128'(0));
        end
    endtask

    initial begin
        logic [127:0] s1[$];
        logic [127:0] lit;
        logic [31:0]  l0, l1, l2, l3;
        int           n;
        int           neq;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 128'(pkt_ready), 128'(0));
        chk("rst_outs", 128'({amm_write, amm_read, busy}), 128'(0));
        chk("rst_cnt", 128'({wr_cnt, rd_cnt}), 128'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", 128'(pkt_ready), 128'(1));

        // Single-beat FIX write
        send(1'b1, 12'h010, 11'd1, 16'hFFF0, 16'h0FFF, 8'hA5, 1'b0);
        @(negedge clk);
        chk("t1_latency", 128'(amm_write), 128'(1));
        chk("t1_be", 128'(amm_byteenable), 128'(16'h0FF0));
        lit = {16{8'hA5}};
        chk("t1_data", amm_writedata, lit);
        @(negedge clk);
        chk("t1_write_drop", 128'(amm_write), 128'(0));
        chk("t1_ready_back", 128'(pkt_ready), 128'(1));
        wait_idle();
        chk("t1_wr_cnt", 128'(wr_cnt), 128'(stat(1)));

        // Four-beat write with a 3-cycle stall on beat 2
        acc_be.delete();
        wr_hi = 0;
        wait_q = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        send(1'b1, 12'h123, 11'd4, 16'hFF00, 16'h00FF, 8'h5A, 1'b0);
        wait_idle();
        chk("t2_beats", 128'(acc_be.size()), 128'(4));
        if (acc_be.size() == 4) begin
            chk("t2_be0", 128'(acc_be[0]), 128'(16'hFF00));
            chk("t2_be1", 128'(acc_be[1]), 128'(16'hFFFF));
            chk("t2_be2", 128'(acc_be[2]), 128'(16'hFFFF));
            chk("t2_be3", 128'(acc_be[3]), 128'(16'h00FF));
        end
        chk("t2_write_cycles", 128'(wr_hi), 128'(7));

        // Read with 2 stall cycles
        wait_q = '{1'b1, 1'b1};
        send(1'b0, 12'hFFF, 11'd8, 16'h0, 16'h0, 8'h00, 1'b0);
        n = 0;
        @(negedge clk);
        while (amm_read && n < 20) begin
            n++;
            if (n == 1) chk("t3_burst", 128'(amm_burstcount), 128'(8));
            @(negedge clk);
        end
        chk("t3_read_cycles", 128'(n), 128'(3));
        chk("t3_ready_back", 128'(pkt_ready), 128'(1));
        chk("t3_rd_cnt", 128'(rd_cnt), 128'(stat(1)));
        wait_idle();

        // Zero-length packet is dropped
        send(1'b1, 12'h055, 11'd0, 16'hFFFF, 16'hFFFF, 8'h11, 1'b0);
        @(negedge clk);
        chk("t4_no_cmd", 128'({amm_write, amm_read, busy}), 128'(0));
        chk("t4_ready", 128'(pkt_ready), 128'(1));
        @(negedge clk);
        chk("t4_cnts", 128'({wr_cnt, rd_cnt}), 128'({stat(5), stat(1)}));

        // Two identical RND writes under random waitrequest
        rnd_wait = 1'b1;
        acc_data.delete();
        send(1'b1, 12'h200, 11'd3, 16'hFFFF, 16'hFFFF, 8'h3C, 1'b1);
        wait_idle();
        s1 = acc_data;
        acc_data.delete();
        send(1'b1, 12'h200, 11'd3, 16'hFFFF, 16'hFFFF, 8'h3C, 1'b1);
        wait_idle();
        rnd_wait = 1'b0;
        chk("t5_len", 128'(acc_data.size()), 128'(3));
        if (acc_data.size() == 3 && s1.size() == 3) begin
            for (int k = 0; k < 3; k++) chk("t5_repeat", acc_data[k], s1[k]);
            lit = {32'h3C3C3C3F, 32'h3C3C3C3E, 32'h3C3C3C3D, 32'h3C3C3C3C};
            chk("t5_seed", acc_data[0], lit);
            lit = {32'h9E3E1E1C, 32'h1E1E1E1F, 32'h9E3E1E1D, 32'h1E1E1E1E};
            chk("t5_step1", acc_data[1], lit);
            l0 = acc_data[0][31:0];   l1 = acc_data[0][63:32];
            l2 = acc_data[0][95:64];  l3 = acc_data[0][127:96];
            neq = int'(l0 == l1) + int'(l0 == l2) + int'(l0 == l3) +
                  int'(l1 == l2) + int'(l1 == l3) + int'(l2 == l3);
            chk("t5_lanes_differ", 128'(neq), 128'(0));
        end

        // Reset on beat 2 of a 5-beat write
        send(1'b1, 12'h300, 11'd5, 16'hFFFF, 16'hFFFF, 8'h77, 1'b0);
        @(posedge clk);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("t6_write_clr", 128'({amm_write, amm_read, busy}), 128'(0));
        chk("t6_cnt_clr", 128'({wr_cnt, rd_cnt}), 128'(0));
        exp_q.delete();
        wait_q.delete();
        m_wr = 0;
        m_rd = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t6_ready", 128'(pkt_ready), 128'(1));
        send(1'b1, 12'h0AB, 11'd2, 16'hF0F0, 16'h0F0F, 8'h96, 1'b0);
        wait_idle();
        chk("t6_new_wr_cnt", 128'(wr_cnt), 128'(stat(2)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
